// File: rtl/nn_sched_pkg.sv
// nn_sched_pkg: shared state encoding and counter widths for the inference sequencer.
package nn_sched_pkg;
  typedef enum logic [1:0] {LOAD, RUN, OUT, ERR} state_t;
  localparam int NUM_INPUTS_DEF = 784;
  localparam int TIMEOUT_DEF = 4096;
  localparam int PIX_CNT_W = $clog2(NUM_INPUTS_DEF);
  localparam int TIMER_W = $clog2(TIMEOUT_DEF);
  localparam int IDX_W = 4;
endpackage

// File: rtl/nn_image_buffer.sv
// nn_image_buffer: pixel shift register with fill counter; first pixel lands in the top byte.
module nn_image_buffer
  import nn_sched_pkg::*;
#(
  parameter int dataWidth = 8,
  parameter int numInputs = 784
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           clr,
  input  logic                           accept,
  input  logic [dataWidth-1:0]           in_data,
  output logic [numInputs*dataWidth-1:0] data,
  output logic                           full
);
  logic [numInputs*dataWidth-1:0] data_q, data_d;
  logic [PIX_CNT_W-1:0]           pix_cnt_q, pix_cnt_d;
  always_comb begin
    full      = accept && pix_cnt_q == PIX_CNT_W'(numInputs - 1);
    data_d    = accept ? {data_q[(numInputs-1)*dataWidth-1:0], in_data} : data_q;
    pix_cnt_d = (clr || full) ? '0 : accept ? pix_cnt_q + PIX_CNT_W'(1) : pix_cnt_q;
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      data_q    <= '0;
      pix_cnt_q <= '0;
    end else begin
      data_q    <= data_d;
      pix_cnt_q <= pix_cnt_d;
    end
  end
  assign data = data_q;
endmodule

// File: rtl/nn_inference_ctrl.sv
// nn_inference_ctrl: loads an image, launches the NN, captures its argmax and
// hands it out over valid/ready, with a RUN watchdog and a delivered-image counter.
module nn_inference_ctrl
  import nn_sched_pkg::*;
#(
  parameter int dataWidth  = 8,
  parameter int numInputs  = 784,
  parameter int numOutputs = 10,
  parameter int TIMEOUT    = 4096
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            clear,
  input  logic [dataWidth-1:0]            in_data,
  input  logic                            in_valid,
  output logic                            in_ready,
  output logic [numInputs*dataWidth-1:0]  NNin,
  output logic                            NNvalid,
  input  logic [numOutputs*dataWidth-1:0] NNout,
  input  logic [IDX_W-1:0]                maxIndex,
  input  logic [dataWidth-1:0]            maxValue,
  input  logic                            maxValid,
  output logic [IDX_W-1:0]                res_index,
  output logic [dataWidth-1:0]            res_value,
  output logic [numOutputs*dataWidth-1:0] res_scores,
  output logic                            res_valid,
  input  logic                            res_ready,
  output logic                            busy,
  output logic                            timeout_err,
  output logic [15:0]                     img_count
);
  state_t                          state_q, state_d;
  logic [TIMER_W-1:0]              timer_q, timer_d;
  logic                            err_q, err_d;
  logic [15:0]                     cnt_q, cnt_d;
  logic [IDX_W-1:0]                idx_q, idx_d;
  logic [dataWidth-1:0]            val_q, val_d;
  logic [numOutputs*dataWidth-1:0] sc_q, sc_d;
  logic                            accept, full, capture;

  assign accept = in_valid && state_q == LOAD && !clear;

  nn_image_buffer #(.dataWidth(dataWidth), .numInputs(numInputs)) u_buf (
    .clk(clk), .reset(reset), .clr(clear), .accept(accept),
    .in_data(in_data), .data(NNin), .full(full)
  );

  always_comb begin
    // timer_q == 0 marks the first RUN cycle, where a stale maxValid is ignored
    capture = !clear && state_q == RUN && timer_q != '0 && maxValid;
    idx_d   = capture ? maxIndex : idx_q;
    val_d   = capture ? maxValue : val_q;
    sc_d    = capture ? NNout : sc_q;
    timer_d = (state_q == RUN && !clear) ? timer_q + TIMER_W'(1) : '0;
    state_d = state_q;
    err_d   = err_q;
    cnt_d   = cnt_q;
    if (clear) begin
      state_d = LOAD;
      err_d   = 1'b0;
      cnt_d   = '0;
    end else if (state_q == LOAD && full) state_d = RUN;
    else if (capture) state_d = OUT;
    else if (state_q == RUN && timer_q == TIMER_W'(TIMEOUT - 1)) begin
      state_d = ERR;
      err_d   = 1'b1;
    end else if (state_q == OUT && res_ready) begin
      state_d = LOAD;
      cnt_d   = cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= LOAD;
      timer_q <= '0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
      idx_q   <= '0;
      val_q   <= '0;
      sc_q    <= '0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      val_q   <= val_d;
      sc_q    <= sc_d;
    end
  end

  assign in_ready    = state_q == LOAD;
  assign NNvalid     = state_q == RUN;
  assign res_valid   = state_q == OUT;
  assign busy        = state_q != LOAD;
  assign timeout_err = err_q;
  assign img_count   = cnt_q;
  assign res_index   = idx_q;
  assign res_value   = val_q;
  assign res_scores  = sc_q;
endmodule

// File: tb/tb_nn_inference_ctrl.sv
// tb_nn_inference_ctrl: directed checks of load, capture, handshake, watchdog,
// stale-result guard and mid-image reset; a second instance uses TIMEOUT=16.
module tb_nn_inference_ctrl;
  localparam int DW = 8, NI = 784, NO = 10;
  logic clk = 0, reset = 0, clear = 0, in_valid = 0, maxValid = 0, res_ready = 0;
  logic [DW-1:0] in_data = '0, maxValue = '0;
  logic [3:0] maxIndex = '0;
  logic [NO*DW-1:0] NNout = 80'h0102_0304_0506_0708_5A0A;
  logic in_ready, NNvalid, res_valid, busy, timeout_err;
  logic [NI*DW-1:0] NNin;
  logic [3:0] res_index;
  logic [DW-1:0] res_value;
  logic [NO*DW-1:0] res_scores;
  logic [15:0] img_count;
  logic t_in_ready, t_NNvalid, t_res_valid, t_busy, t_timeout_err;
  logic [NI*DW-1:0] t_NNin;
  logic [3:0] t_res_index;
  logic [DW-1:0] t_res_value;
  logic [NO*DW-1:0] t_res_scores;
  logic [15:0] t_img_count;
  int n_cmp = 0, n_bad = 0;

  nn_inference_ctrl dut (
    .clk(clk), .reset(reset), .clear(clear), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .NNin(NNin), .NNvalid(NNvalid), .NNout(NNout),
    .maxIndex(maxIndex), .maxValue(maxValue), .maxValid(maxValid),
    .res_index(res_index), .res_value(res_value), .res_scores(res_scores),
    .res_valid(res_valid), .res_ready(res_ready), .busy(busy),
    .timeout_err(timeout_err), .img_count(img_count)
  );

  nn_inference_ctrl #(.TIMEOUT(16)) dut_t (
    .clk(clk), .reset(reset), .clear(clear), .in_data(in_data), .in_valid(in_valid),
    .in_ready(t_in_ready), .NNin(t_NNin), .NNvalid(t_NNvalid), .NNout(NNout),
    .maxIndex(maxIndex), .maxValue(maxValue), .maxValid(maxValid),
    .res_index(t_res_index), .res_value(t_res_value), .res_scores(t_res_scores),
    .res_valid(t_res_valid), .res_ready(res_ready), .busy(t_busy),
    .timeout_err(t_timeout_err), .img_count(t_img_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] pix(input int s, input int i);
    return 8'((i * 31 + s * 17) ^ (i >> 4));
  endfunction

  task automatic load_img(input int s);
    for (int i = 0; i < NI; i++) begin
      in_data = pix(s, i);
      in_valid = 1;
      if (i == NI - 1) chk("nnvalid_before_last", 128'(NNvalid), 0);
      @(negedge clk);
    end
    in_valid = 0;
    chk("nnvalid_after_last", 128'(NNvalid), 1);
    chk("busy_run", 128'(busy), 1);
    chk("in_ready_run", 128'(in_ready), 0);
  endtask

  task automatic chk_img(input int s);
    for (int k = 0; k < NI; k++) chk("nnin_byte", 128'(NNin[(NI-1-k)*DW +: DW]), 128'(pix(s, k)));
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    repeat (3) @(negedge clk);
    reset = 1;
    @(negedge clk);
    chk("rst_in_ready", 128'(in_ready), 1);
    chk("rst_nnvalid", 128'(NNvalid), 0);
    chk("rst_res_valid", 128'(res_valid), 0);
    chk("rst_busy", 128'(busy), 0);
    chk("rst_timeout", 128'(timeout_err), 0);
    chk("rst_img_count", 128'(img_count), 0);
    chk("rst_res_scores", 128'(res_scores), 0);
    chk("rst_nnin_low", 128'(NNin[DW-1:0]), 0);
    // image load and launch
    load_img(1);
    chk_img(1);
    // stalled source during RUN must not disturb the image
    in_valid = 1;
    in_data = 8'hEE;
    for (int k = 0; k < 19; k++) @(negedge clk);
    in_valid = 0;
    chk("nnin_frozen_top", 128'(NNin[NI*DW-1 -: DW]), 128'(pix(1, 0)));
    chk("nnin_frozen_low", 128'(NNin[DW-1:0]), 128'(pix(1, NI - 1)));
    chk("still_run", 128'(NNvalid), 1);
    maxValid = 1;
    maxIndex = 4'd7;
    maxValue = 8'h5A;
    @(negedge clk);
    maxValid = 0;
    chk("res_valid", 128'(res_valid), 1);
    chk("res_index", 128'(res_index), 7);
    chk("res_value", 128'(res_value), 128'h5A);
    chk("res_scores", 128'(res_scores), 128'(80'h0102_0304_0506_0708_5A0A));
    chk("nnvalid_out", 128'(NNvalid), 0);
    maxIndex = 4'd2;
    maxValue = 8'h00;
    NNout = '0;
    for (int k = 0; k < 10; k++) begin
      chk("hold_res_valid", 128'(res_valid), 1);
      chk("hold_res_index", 128'(res_index), 7);
      chk("hold_res_value", 128'(res_value), 128'h5A);
      chk("hold_res_scores", 128'(res_scores), 128'(80'h0102_0304_0506_0708_5A0A));
      chk("hold_img_count", 128'(img_count), 0);
      @(negedge clk);
    end
    res_ready = 1;
    @(negedge clk);
    res_ready = 0;
    chk("hs_img_count", 128'(img_count), 1);
    chk("hs_in_ready", 128'(in_ready), 1);
    chk("hs_res_valid", 128'(res_valid), 0);
    // short-timeout instance has been waiting in ERR since the 20-cycle run
    chk("t_err_sticky", 128'(t_timeout_err), 1);
    chk("t_err_in_ready", 128'(t_in_ready), 0);
    clear = 1;
    @(negedge clk);
    clear = 0;
    chk("clr_img_count", 128'(img_count), 0);
    chk("clr_res_kept", 128'(res_index), 7);
    chk("clr_t_err", 128'(t_timeout_err), 0);
    chk("clr_t_in_ready", 128'(t_in_ready), 1);
    // watchdog: no NN response
    load_img(2);
    for (int k = 0; k < 16; k++) begin
      chk("t_no_timeout_yet", 128'(t_timeout_err), 0);
      @(negedge clk);
    end
    chk("t_timeout_at_16", 128'(t_timeout_err), 1);
    chk("t_err_nnvalid", 128'(t_NNvalid), 0);
    chk("t_err_res_valid", 128'(t_res_valid), 0);
    chk("long_no_timeout", 128'(timeout_err), 0);
    chk("long_still_run", 128'(NNvalid), 1);
    in_valid = 1;
    for (int k = 0; k < 5; k++) begin
      chk("t_err_hold_in_ready", 128'(t_in_ready), 0);
      @(negedge clk);
    end
    in_valid = 0;
    clear = 1;
    @(negedge clk);
    clear = 0;
    chk("t_err_cleared", 128'(t_timeout_err), 0);
    chk("t_ready_after_clear", 128'(t_in_ready), 1);
    chk("ready_after_clear", 128'(in_ready), 1);
    // stale maxValid in first RUN cycle is ignored
    load_img(3);
    maxValid = 1;
    maxIndex = 4'd3;
    maxValue = 8'h11;
    @(negedge clk);
    maxValid = 0;
    chk("stale_res_valid", 128'(res_valid), 0);
    chk("stale_still_run", 128'(NNvalid), 1);
    chk("stale_index_kept", 128'(res_index), 7);
    maxValid = 1;
    @(negedge clk);
    maxValid = 0;
    chk("second_res_valid", 128'(res_valid), 1);
    chk("second_res_index", 128'(res_index), 3);
    chk("second_res_value", 128'(res_value), 128'h11);
    res_ready = 1;
    @(negedge clk);
    res_ready = 0;
    chk("second_img_count", 128'(img_count), 1);
    chk("second_in_ready", 128'(in_ready), 1);
    // reset in the middle of an image
    for (int i = 0; i < 400; i++) begin
      in_data = pix(4, i);
      in_valid = 1;
      @(negedge clk);
    end
    in_valid = 0;
    reset = 0;
    @(negedge clk);
    reset = 1;
    @(negedge clk);
    chk("mid_rst_in_ready", 128'(in_ready), 1);
    chk("mid_rst_nnvalid", 128'(NNvalid), 0);
    chk("mid_rst_img_count", 128'(img_count), 0);
    chk("mid_rst_nnin", 128'(NNin[DW-1:0]), 0);
    load_img(5);
    chk_img(5);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/nn_inference_ctrl.md
# nn_inference_ctrl

Sequencer that feeds the `NeuralNetwork` datapath one image at a time. It assembles a 784-pixel image from a byte stream, launches inference by driving `NNvalid`, waits for the argmax result, and returns it over a valid/ready result port. It also applies a watchdog timeout and keeps an image counter. It sits between the host-side pixel source (UART/memory reader) and the `NeuralNetwork` instance.

## Interface
Parameters:
- `dataWidth`, 8: pixel and output width.
- `numInputs`, 784: pixels per image.
- `numOutputs`, 10: NN output count.
- `TIMEOUT`, 4096: maximum cycles spent in RUN before error.

Ports:
- Clocking and reset: one clock; reset is asynchronous and active-low.
  - `clk`  in  1  clock.
  - `reset`  in  1  asynchronous active-low reset.
- `clear`  in  1  synchronous abort and restart.
- `in_data`  in  dataWidth  pixel byte.
- `in_valid`  in  1  pixel valid.
- `in_ready`  out  1  controller accepts pixel.
- `NNin`  out  numInputs*dataWidth  image to NN.
- `NNvalid`  out  1  inference request.
- `NNout`  in  numOutputs*dataWidth  raw NN outputs.
- `maxIndex`  in  4  NN argmax index.
- `maxValue`  in  dataWidth  NN argmax value.
- `maxValid`  in  1  NN result valid.
- `res_index`  out  4  captured index.
- `res_value`  out  dataWidth  captured value.
- `res_scores`  out  numOutputs*dataWidth  captured NNout.
- `res_valid`  out  1  result available.
- `res_ready`  in  1  result consumer ready.
- `busy`  out  1  state is not LOAD.
- `timeout_err`  out  1  watchdog fired; sticky.
- `img_count`  out  16  results delivered (wraps).

## Operation
- States: LOAD, RUN, OUT, ERR.
- LOAD:
  - `in_ready`=1.
  - On `in_valid & in_ready`: `NNin <= {NNin[(numInputs-1)*dataWidth-1:0], in_data}`, `pix_cnt++`. The first pixel received ends up in the top byte.
  - An accept with `pix_cnt == numInputs-1` goes to RUN and clears `pix_cnt` and the timer.
- RUN:
  - `NNvalid`=1 (level, held), `in_ready`=0, `NNin` frozen.
  - `maxValid` is ignored in the first RUN cycle, which guards against a stale result.
  - From the second cycle, `maxValid` captures `maxIndex`, `maxValue` and `NNout` into the `res_*` registers and goes to OUT.
  - Otherwise, `timer == TIMEOUT-1` sets `timeout_err` and goes to ERR.
  - If `maxValid` and timeout occur in the same cycle, `maxValid` wins.
- OUT:
  - `NNvalid`=0, `res_valid`=1, `res_*` stable.
  - On `res_ready`: `img_count++` (wraps at 2^16), go to LOAD.
- ERR: `NNvalid`=0, `res_valid`=0, `in_ready`=0; held until `clear`.
- `clear` has priority over all transitions in any state. It goes to LOAD and zeroes `pix_cnt`, timer, `timeout_err` and `img_count`. `NNin` and `res_*` are retained.
- Reset values: state LOAD, `NNin`=0, `NNvalid`=0, `in_ready`=1, `res_*`=0, `res_valid`=0, `busy`=0, `timeout_err`=0, `img_count`=0.
- Reset mid-operation aborts immediately. No partial image is kept (`pix_cnt`=0).
- `in_valid` while `in_ready`=0 is not consumed; the source holds the data.

## Timing
- Last pixel accepted at cycle T: `NNvalid`=1 and `busy`=1 from T+1.
- `maxValid` sampled at cycle M (M ≥ T+2): `res_valid`=1 and `NNvalid`=0 from M+1.
- Handshake at R (`res_valid & res_ready`): `in_ready`=1 at R+1. Back-to-back images are therefore possible with no idle cycles beyond these.
- Timeout: with no `maxValid`, `timeout_err` asserts at T+1+TIMEOUT.
- All outputs are registered. No combinational path from inputs to outputs except none; `in_ready` is decoded from the state register.

## Structure
- Package `nn_sched_pkg`:
  - `state_t` enum {LOAD, RUN, OUT, ERR}.
  - `PIX_CNT_W = $clog2(numInputs)`.
  - `TIMER_W = $clog2(TIMEOUT)`.
  - `IDX_W = 4`.
- Sub-module `nn_image_buffer`: the shift register plus `pix_cnt`, with an `accept`/`clr` input and a `full` pulse output. The FSM, timer and result registers stay in `nn_inference_ctrl`.

## Test plan
- Load the 784 bytes of `mem[1]` from `flattened_inputs_hex.mif` with `in_valid` held high. Require:
  - `NNin == mem[1]`.
  - `NNvalid` rises exactly 1 cycle after the 784th accept.
- NN model asserts `maxValid` with `maxIndex`=7 and `maxValue`=8'h5A, 20 cycles into RUN. Require:
  - `res_valid` the next cycle, `res_index`=7, `res_value`=8'h5A.
  - `res_scores` equals `NNout`.
  - `NNvalid`=0.
- Hold `res_ready`=0 for 10 cycles, then 1. Require:
  - `res_*` stable throughout.
  - `img_count` goes 0→1.
  - `in_ready` is 1 the cycle after the handshake.
- NN never responds with `TIMEOUT`=16. Require:
  - `timeout_err`=1 exactly 16 cycles after `NNvalid` rises.
  - `in_ready` stays 0 until `clear`, and after `clear` `timeout_err`=0.
- Assert `maxValid` in the first RUN cycle. Require that it is ignored and the state stays RUN.
- Assert `reset` low after pixel 400. Require that after release:
  - `pix_cnt`=0.
  - A full new 784-byte image is needed before `NNvalid`.
